// File: rtl/counter_sequencer_if.sv
// Command channel for counter_sequencer: one count job (start, end, reload mode)
// transferred on a valid/ready handshake.
interface counter_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_start;
   logic [WIDTH-1:0] cmd_end;
   logic             cmd_reload;

   modport master (
      output cmd_valid,
      output cmd_start,
      output cmd_end,
      output cmd_reload,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_start,
      input  cmd_end,
      input  cmd_reload,
      output cmd_ready
   );
endinterface

// File: rtl/counter_sequencer.sv
// Job controller around an external loadable up-counter: loads the start value,
// enables counting until the count equals the terminal value, then pulses done.
module counter_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   counter_sequencer_if.slave  cmd,
   input  logic                abort,
   input  logic                pause,
   output logic                ctr_load,
   output logic                ctr_enable,
   output logic [WIDTH-1:0]    ctr_data,
   input  logic [WIDTH-1:0]    ctr_count,
   output logic                busy,
   output logic                done
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] start_reg, end_reg;
   logic             reload_reg;
   logic             accept;
   logic             terminal;

   assign accept        = cmd.cmd_valid && (state_reg == IDLE);
   assign terminal      = (ctr_count == end_reg);
   assign cmd.cmd_ready = (state_reg == IDLE);
   assign busy          = (state_reg != IDLE);
   // The counter only samples data while loading, so the latched start can drive it permanently.
   assign ctr_data      = start_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         start_reg  <= '0;
         end_reg    <= '0;
         reload_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            start_reg  <= cmd.cmd_start;
            end_reg    <= cmd.cmd_end;
            reload_reg <= cmd.cmd_reload;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      ctr_load   = 1'b0;
      ctr_enable = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept)
               state_next = LOAD;
         end
         LOAD: begin
            ctr_load   = 1'b1;
            state_next = abort ? IDLE : RUN;
         end
         RUN: begin
            // Terminal detection ignores pause; abort suppresses both done and counting.
            ctr_enable = !terminal && !pause && !abort;
            if (abort) begin
               state_next = IDLE;
            end else if (terminal) begin
               done       = 1'b1;
               state_next = reload_reg ? LOAD : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench: directed scenarios plus randomized jobs scored against a
// cycle schedule derived from the job rules; the bench models the external counter.
module tb_counter_sequencer;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             abort;
   logic             pause;
   logic             ctr_load;
   logic             ctr_enable;
   logic [WIDTH-1:0] ctr_data;
   logic [WIDTH-1:0] ctr_count = '0;
   logic             busy;
   logic             done;

   int tests = 0;
   int fails = 0;

   counter_sequencer_if #(.WIDTH(WIDTH)) cmd ();

   counter_sequencer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd        (cmd.slave),
      .abort      (abort),
      .pause      (pause),
      .ctr_load   (ctr_load),
      .ctr_enable (ctr_enable),
      .ctr_data   (ctr_data),
      .ctr_count  (ctr_count),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // External counter: load wins over enable, wraps naturally.
   always_ff @(posedge clk) begin
      if (ctr_load)
         ctr_count <= ctr_data;
      else if (ctr_enable)
         ctr_count <= ctr_count + 1'b1;
   end

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      advance();
      advance();
      sample();
      tests += 6;
      if (cmd.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", cmd.cmd_ready); end
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
      if (ctr_load !== 1'b0) begin fails++; $display("FAIL reset_load: got %b expected 0", ctr_load); end
      if (ctr_enable !== 1'b0) begin fails++; $display("FAIL reset_enable: got %b expected 0", ctr_enable); end
      if (ctr_data !== '0) begin fails++; $display("FAIL reset_data: got %0d expected 0", ctr_data); end
      $display("[TB] reset checked");
      reset = 1'b0;
      advance();
   endtask

   task automatic test_oneshot(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] e);
      logic [WIDTH-1:0] steps;
      logic [WIDTH-1:0] exp_cnt;
      steps = e - s;
      cmd.cmd_valid = 1'b1; cmd.cmd_start = s; cmd.cmd_end = e; cmd.cmd_reload = 1'b0;
      sample();
      tests++;
      if (cmd.cmd_ready !== 1'b1) begin fails++; $display("FAIL oneshot_accept: got %b expected 1", cmd.cmd_ready); end
      advance();
      cmd.cmd_valid = 1'b0; cmd.cmd_start = WIDTH'($urandom); cmd.cmd_end = WIDTH'($urandom);
      sample();
      tests += 3;
      if (ctr_load !== 1'b1) begin fails++; $display("FAIL oneshot_load: got %b expected 1", ctr_load); end
      if (ctr_data !== s) begin fails++; $display("FAIL oneshot_data: got %0d expected %0d", ctr_data, s); end
      if (ctr_enable !== 1'b0) begin fails++; $display("FAIL oneshot_load_enable: got %b expected 0", ctr_enable); end
      advance();
      for (int k = 0; k <= int'(steps); k++) begin
         exp_cnt = s + WIDTH'(k);
         sample();
         tests += 4;
         if (ctr_count !== exp_cnt) begin fails++; $display("FAIL oneshot_count: got %0d expected %0d", ctr_count, exp_cnt); end
         if (ctr_enable !== (k < int'(steps))) begin fails++; $display("FAIL oneshot_enable: got %b expected %b", ctr_enable, k < int'(steps)); end
         if (done !== (k == int'(steps))) begin fails++; $display("FAIL oneshot_done: got %b expected %b", done, k == int'(steps)); end
         if (cmd.cmd_ready !== 1'b0) begin fails++; $display("FAIL oneshot_ready_busy: got %b expected 0", cmd.cmd_ready); end
         advance();
      end
      sample();
      tests += 3;
      if (busy !== 1'b0) begin fails++; $display("FAIL oneshot_end_busy: got %b expected 0", busy); end
      if (cmd.cmd_ready !== 1'b1) begin fails++; $display("FAIL oneshot_end_ready: got %b expected 1", cmd.cmd_ready); end
      if (done !== 1'b0) begin fails++; $display("FAIL oneshot_end_done: got %b expected 0", done); end
      $display("[TB] oneshot start=%0d end=%0d checked", s, e);
      advance();
   endtask

   task automatic test_pause();
      logic [WIDTH-1:0] exp_cnt [6];
      bit               exp_en  [6];
      exp_cnt = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
      exp_en  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      cmd.cmd_valid = 1'b1; cmd.cmd_start = 8'd0; cmd.cmd_end = 8'd3; cmd.cmd_reload = 1'b0;
      sample();
      advance();
      cmd.cmd_valid = 1'b0;
      sample();
      tests++;
      if (ctr_load !== 1'b1) begin fails++; $display("FAIL pause_load: got %b expected 1", ctr_load); end
      advance();
      for (int i = 0; i < 6; i++) begin
         pause = (i == 1) || (i == 2);
         sample();
         tests += 3;
         if (ctr_count !== exp_cnt[i]) begin fails++; $display("FAIL pause_count: got %0d expected %0d", ctr_count, exp_cnt[i]); end
         if (ctr_enable !== exp_en[i]) begin fails++; $display("FAIL pause_enable: got %b expected %b", ctr_enable, exp_en[i]); end
         if (done !== (i == 5)) begin fails++; $display("FAIL pause_done: got %b expected %b", done, i == 5); end
         advance();
      end
      pause = 1'b0;
      sample();
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL pause_end_busy: got %b expected 0", busy); end
      $display("[TB] pause scenario checked");
      advance();
   endtask

   task automatic test_reload_abort();
      logic [WIDTH-1:0] exp_cnt;
      cmd.cmd_valid = 1'b1; cmd.cmd_start = 8'd0; cmd.cmd_end = 8'd2; cmd.cmd_reload = 1'b1;
      sample();
      advance();
      cmd.cmd_start = 8'd50; cmd.cmd_end = 8'd60; cmd.cmd_reload = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         abort = (c == 14);
         exp_cnt = WIDTH'((c + 2) % 4);
         sample();
         tests += 4;
         if (cmd.cmd_ready !== 1'b0) begin fails++; $display("FAIL reload_ready: cycle %0d got %b expected 0", c, cmd.cmd_ready); end
         if (busy !== 1'b1) begin fails++; $display("FAIL reload_busy: cycle %0d got %b expected 1", c, busy); end
         if (done !== (c % 4 == 0)) begin fails++; $display("FAIL reload_done: cycle %0d got %b expected %b", c, done, c % 4 == 0); end
         if (ctr_load !== (c % 4 == 1)) begin fails++; $display("FAIL reload_load: cycle %0d got %b expected %b", c, ctr_load, c % 4 == 1); end
         if (c % 4 != 1) begin
            tests++;
            if (ctr_count !== exp_cnt) begin fails++; $display("FAIL reload_count: cycle %0d got %0d expected %0d", c, ctr_count, exp_cnt); end
         end
         if (c == 14) begin
            tests++;
            if (ctr_enable !== 1'b0) begin fails++; $display("FAIL abort_enable: got %b expected 0", ctr_enable); end
         end
         advance();
      end
      abort = 1'b0;
      cmd.cmd_valid = 1'b0;
      for (int c = 15; c <= 16; c++) begin
         sample();
         tests += 2;
         if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: cycle %0d got %b expected 0", c, busy); end
         if (done !== 1'b0) begin fails++; $display("FAIL abort_done: cycle %0d got %b expected 0", c, done); end
         advance();
      end
      $display("[TB] reload/abort scenario checked");
   endtask

   task automatic test_reset_midjob();
      cmd.cmd_valid = 1'b1; cmd.cmd_start = 8'd0; cmd.cmd_end = 8'd10; cmd.cmd_reload = 1'b0;
      sample();
      advance();
      cmd.cmd_valid = 1'b0;
      advance();
      advance();
      reset = 1'b1;
      sample();
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL midjob_busy: got %b expected 1", busy); end
      advance();
      reset = 1'b0;
      sample();
      tests += 6;
      if (busy !== 1'b0) begin fails++; $display("FAIL midjob_reset_busy: got %b expected 0", busy); end
      if (cmd.cmd_ready !== 1'b1) begin fails++; $display("FAIL midjob_reset_ready: got %b expected 1", cmd.cmd_ready); end
      if (ctr_load !== 1'b0) begin fails++; $display("FAIL midjob_reset_load: got %b expected 0", ctr_load); end
      if (ctr_enable !== 1'b0) begin fails++; $display("FAIL midjob_reset_enable: got %b expected 0", ctr_enable); end
      if (ctr_data !== '0) begin fails++; $display("FAIL midjob_reset_data: got %0d expected 0", ctr_data); end
      if (done !== 1'b0) begin fails++; $display("FAIL midjob_reset_done: got %b expected 0", done); end
      advance();
      cmd.cmd_valid = 1'b1; cmd.cmd_start = 8'd5; cmd.cmd_end = 8'd7;
      sample();
      advance();
      cmd.cmd_valid = 1'b0;
      sample();
      tests++;
      if (ctr_data !== 8'd5) begin fails++; $display("FAIL midjob_new_data: got %0d expected 5", ctr_data); end
      advance();
      for (int k = 0; k < 3; k++) begin
         sample();
         tests += 2;
         if (ctr_count !== WIDTH'(5 + k)) begin fails++; $display("FAIL midjob_new_count: got %0d expected %0d", ctr_count, 5 + k); end
         if (done !== (k == 2)) begin fails++; $display("FAIL midjob_new_done: got %b expected %b", done, k == 2); end
         advance();
      end
      sample();
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL midjob_new_busy: got %b expected 0", busy); end
      $display("[TB] reset mid-job checked");
      advance();
   endtask

   task automatic test_random(input int n_jobs);
      bit               pz     [64];
      bit               e_load [64];
      bit               e_done [64];
      bit               e_busy [64];
      bit               e_en   [64];
      bit               run_c  [64];
      logic [WIDTH-1:0] e_cnt  [64];
      logic [WIDTH-1:0] s, e, cnt;
      int               steps, rem, abort_at, c, len;
      bit               rl;
      for (int j = 0; j < n_jobs; j++) begin
         s        = WIDTH'($urandom);
         steps    = $urandom_range(0, 10);
         e        = s + WIDTH'(steps);
         rl       = 1'($urandom_range(0, 1));
         abort_at = rl ? $urandom_range(12, 40) : 64;
         for (int i = 0; i < 64; i++) begin
            pz[i] = ($urandom_range(0, 3) == 0);
            e_load[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_en[i] = 0; run_c[i] = 0; e_cnt[i] = '0;
         end
         // Schedule: one load cycle, then one cycle per step plus one per paused step, then done.
         c = 1;
         while (c < abort_at && c < 64) begin
            e_load[c] = 1; e_busy[c] = 1; c++;
            rem = steps; cnt = s;
            while (c < abort_at && c < 64) begin
               e_busy[c] = 1; run_c[c] = 1; e_cnt[c] = cnt;
               if (rem == 0) begin e_done[c] = 1; c++; break; end
               if (!pz[c]) begin e_en[c] = 1; rem--; cnt++; end
               c++;
            end
            if (!rl) break;
         end
         if (abort_at < 64) e_busy[abort_at] = 1;
         len = rl ? abort_at + 2 : ((c + 1 < 64) ? c + 1 : 64);
         for (int t = 0; t < len; t++) begin
            cmd.cmd_valid = (t == 0);
            if (t == 0) begin cmd.cmd_start = s; cmd.cmd_end = e; cmd.cmd_reload = rl; end
            pause = pz[t];
            abort = (t == abort_at);
            sample();
            tests += 2;
            if (busy !== e_busy[t]) begin fails++; $display("FAIL rand_busy: job %0d cycle %0d got %b expected %b", j, t, busy, e_busy[t]); end
            if (done !== e_done[t]) begin fails++; $display("FAIL rand_done: job %0d cycle %0d got %b expected %b", j, t, done, e_done[t]); end
            if (t != abort_at) begin
               tests++;
               if (ctr_load !== e_load[t]) begin fails++; $display("FAIL rand_load: job %0d cycle %0d got %b expected %b", j, t, ctr_load, e_load[t]); end
            end
            if (run_c[t]) begin
               tests++;
               if (ctr_count !== e_cnt[t]) begin fails++; $display("FAIL rand_count: job %0d cycle %0d got %0d expected %0d", j, t, ctr_count, e_cnt[t]); end
               if (t != abort_at) begin
                  tests++;
                  if (ctr_enable !== e_en[t]) begin fails++; $display("FAIL rand_enable: job %0d cycle %0d got %b expected %b", j, t, ctr_enable, e_en[t]); end
               end
            end
            advance();
         end
         pause = 1'b0;
         abort = 1'b0;
         cmd.cmd_valid = 1'b0;
         $display("[TB] random job %0d start=%0d end=%0d reload=%0d checked", j, s, e, rl);
      end
   endtask

   initial begin
      reset = 1'b1; abort = 1'b0; pause = 1'b0;
      cmd.cmd_valid = 1'b0; cmd.cmd_start = '0; cmd.cmd_end = '0; cmd.cmd_reload = 1'b0;
      test_reset();
      test_oneshot(8'd3, 8'd6);
      test_oneshot(8'd9, 8'd9);
      test_oneshot(8'd254, 8'd1);
      test_pause();
      test_reload_abort();
      test_reset_midjob();
      test_random(30);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Command-driven controller for one loadable up-counter instance: loadable, enable-gated, increments by 1, count registered. Counter data path is WIDTH bits.
- Accepts a count job (start value, terminal value, one-shot or auto-reload) over a valid/ready handshake.
- Drives the counter's load/enable/data inputs and watches its count output.
- Signals job completion with a one-cycle done pulse. Used wherever a programmable interval timer or step sequencer is needed around the shared counter.

Parameters:
- WIDTH, 8, width of counter data/count and of command start/end fields.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command (high only in IDLE).
- cmd_start  in  WIDTH  counter load value.
- cmd_end  in  WIDTH  terminal count value.
- cmd_reload  in  1  1 = auto-reload (periodic), 0 = one-shot.
- abort  in  1  cancel current job.
- pause  in  1  hold counting (enable forced low).
- ctr_load  out  1  to counter load.
- ctr_enable  out  1  to counter enable.
- ctr_data  out  WIDTH  to counter data.
- ctr_count  in  WIDTH  from counter count.
- busy  out  1  job active (state != IDLE).
- done  out  1  one-cycle pulse at terminal count.

Behaviour:
- Counter timing contract: ctr_load or ctr_enable asserted in cycle t takes effect in ctr_count at cycle t+1. Counter wraps modulo 2^WIDTH. The counter's own reset is not driven by this block.
- Reset: state IDLE, cmd_ready=1, busy=0, done=0, ctr_load=0, ctr_enable=0, ctr_data=0, latched start/end/reload = 0. Reset mid-job returns to IDLE the next cycle with no done pulse.
- FSM states: IDLE, LOAD, RUN.
- IDLE: cmd_ready=1. Handshake occurs when cmd_valid && cmd_ready. On handshake, latch cmd_start, cmd_end and cmd_reload; next state LOAD. A command is never accepted outside IDLE.
- LOAD: ctr_load=1, ctr_data=start_q, ctr_enable=0.
  - abort → IDLE.
  - otherwise → RUN.
- RUN: ctr_load=0.
  - terminal = (ctr_count == end_q).
  - ctr_enable = !terminal && !pause && !abort.
  - abort (highest priority) → IDLE, no done.
  - terminal → done=1 this cycle; next state LOAD if reload_q, else IDLE.
  - otherwise stay in RUN.
- pause does not mask terminal detection.
- Step count per period = (end_q − start_q) mod 2^WIDTH. end < start is legal and wraps through 0. start == end gives done in the first RUN cycle with no enable.
- One-shot latency from handshake cycle h: done at cycle h+2+steps+paused_cycles; busy low at h+3+steps+paused_cycles.
- Auto-reload: period = steps+2 cycles (LOAD + RUN cycles). Runs until abort or reset.
- ctr_data holds start_q in all states after the first load; it is don't-care when ctr_load=0.
- busy = (state != IDLE). cmd_ready = (state == IDLE).
- abort in IDLE has no effect.

Test Plan:
- WIDTH=8, handshake at cycle 0, start=3, end=6, reload=0 → ctr_load cycle 1; count 3,4,5,6 at cycles 2–5; ctr_enable high cycles 2–4; done cycle 5 only; busy low and cmd_ready high at cycle 6.
- start=9, end=9, one-shot → LOAD cycle 1, done cycle 2, ctr_enable never asserted, IDLE cycle 3.
- start=254, end=1, one-shot → count 254,255,0,1 at cycles 2–5; done cycle 5.
- start=0, end=3, pause high cycles 3–4 → count 0,1,1,1,2,3 at cycles 2–7; done cycle 7; ctr_enable low cycles 3–4.
- start=0, end=2, reload=1 → done at cycles 4, 8, 12. abort at cycle 14 → IDLE at cycle 15, no further done. cmd_valid held high during cycles 1–14 is not accepted (cmd_ready=0).
- reset asserted at cycle 3 of a start=0, end=10 job → cycle 4: IDLE, busy=0, cmd_ready=1, all ctr_* outputs 0, no done. A new command at cycle 5 runs normally.
